// File: rtl/fifo_pkg.sv
// ----------------------------------------------------------------------------
// fifo_pkg
// Definitions shared between the write side of the async FIFO and the
// read-side packer: default entry width / depth and the packer FSM state type.
// ----------------------------------------------------------------------------
package fifo_pkg;

    localparam int FIFO_WIDTH = 8;
    localparam int FIFO_DEPTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        EMIT = 2'd3
    } rd_pk_state_t;

endpackage

// File: rtl/fifo_rd_packer_if.sv
// ----------------------------------------------------------------------------
// fifo_rd_packer_if
// Bundles the FIFO read port, the flush request and the packed output stream
// of fifo_rd_packer.
//   master : the packer (drives fifo_rd_en, out_*, err_cnt, timeout_err)
//   slave  : the environment (FIFO + downstream consumer)
// ----------------------------------------------------------------------------
interface fifo_rd_packer_if #(
    parameter int WIDTH = 8,
    parameter int PACK  = 4
);
    localparam int CNT_W = $clog2(PACK) + 1;

    // FIFO read port
    logic                    fifo_empty;
    logic                    fifo_rd_en;
    logic                    fifo_rd_ack;
    logic                    fifo_rd_err;
    logic [WIDTH-1:0]        fifo_dout;

    // Control / output stream
    logic                    flush;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH*PACK-1:0]   out_data;
    logic [CNT_W-1:0]        out_cnt;
    logic [7:0]              err_cnt;
    logic                    timeout_err;

    modport master (
        input  fifo_empty, fifo_rd_ack, fifo_rd_err, fifo_dout, flush, out_ready,
        output fifo_rd_en, out_valid, out_data, out_cnt, err_cnt, timeout_err
    );

    modport slave (
        output fifo_empty, fifo_rd_ack, fifo_rd_err, fifo_dout, flush, out_ready,
        input  fifo_rd_en, out_valid, out_data, out_cnt, err_cnt, timeout_err
    );

endinterface

// File: rtl/fifo_rd_packer_sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
// W-bit up counter that sticks at all-ones.
//   clk, rst_n : clock, asynchronous active-low reset (count -> 0)
//   i_inc      : increment by one (ignored once saturated)
//   i_clr      : synchronous clear, wins over i_inc
//   o_count    : current count
// ----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_inc,
    input  logic         i_clr,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/fifo_rd_packer.sv
// ----------------------------------------------------------------------------
// fifo_rd_packer
// Read-side consumer of the async FIFO (rd_clk domain). Issues one FIFO read
// at a time, packs PACK consecutive WIDTH-bit entries into one word (entry 0
// in the LSBs) and offers it on a valid/ready stream. A flush in IDLE emits a
// partial word; read errors (and optional timeouts) are counted.
//   rd_clk, clear_n : clock, asynchronous active-low reset
//   bus (master)    : FIFO read port, flush, out_valid/out_ready/out_data/
//                     out_cnt, err_cnt, timeout_err
// Build option FIFO_RD_TIMEOUT_EN: abort a WAIT after TIMEOUT silent cycles.
// Without it WAIT waits forever and timeout_err is constant 0.
// ----------------------------------------------------------------------------
module fifo_rd_packer
    import fifo_pkg::*;
#(
    parameter int WIDTH   = FIFO_WIDTH,
    parameter int PACK    = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                rd_clk,
    input  logic                clear_n,
    fifo_rd_packer_if.master    bus
);

    localparam int                IDX_W    = $clog2(PACK) + 1;
    localparam logic [IDX_W-1:0]  PACK_IDX = IDX_W'(PACK);

    if (PACK < 2)    begin : g_bad_pack    $error("PACK must be >= 2");    end
    if (TIMEOUT < 1) begin : g_bad_timeout $error("TIMEOUT must be >= 1"); end

    rd_pk_state_t             r_state;
    rd_pk_state_t             w_next;
    logic [IDX_W-1:0]         r_idx;
    logic [WIDTH*PACK-1:0]    r_lanes;
    logic [IDX_W-1:0]         r_out_cnt;
    logic                     r_rd_en;
    logic                     r_out_valid;
    logic                     r_timeout_err;
    logic                     w_capture;
    logic                     w_rd_err;
    logic                     w_timeout;
    logic [7:0]               w_err_cnt;

`ifdef FIFO_RD_TIMEOUT_EN
    localparam int             TO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    logic [TO_W-1:0]           r_wait_cnt;
`endif

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        w_rd_err  = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            IDLE: begin
                // flush outranks a pending read; an empty word is never emitted
                if (bus.flush && (r_idx != '0)) begin
                    w_next = EMIT;
                end else if (!bus.fifo_empty) begin
                    w_next = REQ;
                end
            end
            REQ: w_next = WAIT;
            WAIT: begin
                if (bus.fifo_rd_err) begin
                    // err wins over a simultaneous ack: the data is dropped
                    w_rd_err = 1'b1;
                    w_next   = IDLE;
                end else if (bus.fifo_rd_ack) begin
                    w_capture = 1'b1;
                    w_next    = ((r_idx + 1'b1) == PACK_IDX) ? EMIT : IDLE;
                end
`ifdef FIFO_RD_TIMEOUT_EN
                else if (r_wait_cnt == TO_LAST) begin
                    w_timeout = 1'b1;
                    w_next    = IDLE;
                end
`endif
            end
            EMIT: begin
                if (bus.out_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge rd_clk or negedge clear_n) begin
        if (!clear_n) begin
            r_state       <= IDLE;
            r_idx         <= '0;
            r_lanes       <= '0;
            r_out_cnt     <= '0;
            r_rd_en       <= 1'b0;
            r_out_valid   <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_next;
            // outputs are decoded from the next state so they line up with it
            r_rd_en       <= (w_next == REQ);
            r_out_valid   <= (w_next == EMIT);
            r_timeout_err <= w_timeout;

            if (w_capture) begin
                r_lanes[int'(r_idx)*WIDTH +: WIDTH] <= bus.fifo_dout;
                r_idx                               <= r_idx + 1'b1;
                if (w_next == EMIT) begin
                    r_out_cnt <= PACK_IDX;
                end
            end

            if ((r_state == IDLE) && (w_next == EMIT)) begin
                r_out_cnt <= r_idx;
            end

            if ((r_state == EMIT) && bus.out_ready) begin
                r_idx   <= '0;
                r_lanes <= '0;
            end
        end
    end

`ifdef FIFO_RD_TIMEOUT_EN
    // Counts cycles spent in WAIT; zero on the first WAIT cycle.
    always_ff @(posedge rd_clk or negedge clear_n) begin
        if (!clear_n) begin
            r_wait_cnt <= '0;
        end else if (r_state != WAIT) begin
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end
    assign bus.timeout_err = r_timeout_err;
`else
    assign bus.timeout_err = 1'b0;
`endif

    sat_counter #(.W(8)) u_err_cnt (
        .clk     (rd_clk),
        .rst_n   (clear_n),
        .i_inc   (w_rd_err | w_timeout),
        .i_clr   (1'b0),
        .o_count (w_err_cnt)
    );

    assign bus.fifo_rd_en = r_rd_en;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_data   = r_lanes;
    assign bus.out_cnt    = r_out_cnt;
    assign bus.err_cnt    = w_err_cnt;

`ifndef FIFO_RD_TIMEOUT_EN
    // Only consumed by the timeout build.
    logic w_unused;
    assign w_unused = r_timeout_err;
`endif

endmodule

// File: tb/tb_fifo_rd_packer.sv
// ----------------------------------------------------------------------------
// tb_fifo_rd_packer
// Directed bench for fifo_rd_packer (WIDTH=8, PACK=4). A behavioural FIFO
// answers each read one cycle after fifo_rd_en with ack (data) or err; the
// expected packed words are queued by the stimulus and popped by a monitor on
// every out_valid & out_ready handshake.
// ----------------------------------------------------------------------------
module tb_fifo_rd_packer;
    import fifo_pkg::*;

    localparam int WIDTH = 8;
    localparam int PACK  = 4;

    typedef struct {
        logic [31:0] data;
        logic [2:0]  cnt;
    } exp_t;

    logic rd_clk;
    logic clear_n;

    fifo_rd_packer_if #(.WIDTH(WIDTH), .PACK(PACK)) bus ();

    fifo_rd_packer #(.WIDTH(WIDTH), .PACK(PACK), .TIMEOUT(15)) dut (
        .rd_clk  (rd_clk),
        .clear_n (clear_n),
        .bus     (bus)
    );

    initial rd_clk = 1'b0;
    always #5 rd_clk = ~rd_clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int beats  = 0;
    int err_given = 0;
    int mode   = 0;          // 0: normal FIFO, 1: answer err, 2: never answer
    logic [7:0] fifo_q[$];
    exp_t       exp_q[$];
    logic       pending = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Behavioural FIFO: a read seen in one cycle is answered in the next.
    always @(negedge rd_clk) begin
        bus.fifo_rd_ack = 1'b0;
        bus.fifo_rd_err = 1'b0;
        if (!clear_n) begin
            pending = 1'b0;
        end else begin
            if (pending) begin
                pending = 1'b0;
                if (mode == 1) begin
                    bus.fifo_rd_err = 1'b1;
                    err_given++;
                end else if (mode == 0) begin
                    if (fifo_q.size() > 0) begin
                        bus.fifo_rd_ack = 1'b1;
                        bus.fifo_dout   = fifo_q.pop_front();
                    end else begin
                        bus.fifo_rd_err = 1'b1;
                    end
                end
            end
            if (bus.fifo_rd_en) pending = 1'b1;
        end
        bus.fifo_empty = (fifo_q.size() == 0);
    end

    // Scoreboard monitor
    always @(negedge rd_clk) begin
        if (clear_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("beat_unexpected", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("beat_data", 64'(bus.out_data), 64'(e.data));
                check("beat_cnt",  64'(bus.out_cnt),  64'(e.cnt));
            end
            beats++;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge rd_clk);
        #2;
    endtask

    task automatic push_exp(input logic [31:0] d, input logic [2:0] c);
        exp_t e;
        e.data = d;
        e.cnt  = c;
        exp_q.push_back(e);
    endtask

    task automatic wait_beats(input string name, input int target);
        for (int i = 0; i < 400 && beats < target; i++) tick();
        check(name, 64'(beats), 64'(target));
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400 && fifo_q.size() > 0; i++) tick();
        tick(10);
    endtask

    task automatic pulse_flush();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
    endtask

    initial begin
        bus.fifo_empty  = 1'b1;
        bus.fifo_rd_ack = 1'b0;
        bus.fifo_rd_err = 1'b0;
        bus.fifo_dout   = '0;
        bus.flush       = 1'b0;
        bus.out_ready   = 1'b1;
        clear_n         = 1'b0;
        tick(3);
        check("rst_rd_en",     64'(bus.fifo_rd_en),  0);
        check("rst_out_valid", 64'(bus.out_valid),   0);
        check("rst_out_data",  64'(bus.out_data),    0);
        check("rst_out_cnt",   64'(bus.out_cnt),     0);
        check("rst_err_cnt",   64'(bus.err_cnt),     0);
        check("rst_timeout",   64'(bus.timeout_err), 0);
        clear_n = 1'b1;
        tick(2);

        // 1: full word
        push_exp(32'h44332211, 3'd4);
        fifo_q.push_back(8'h11); fifo_q.push_back(8'h22);
        fifo_q.push_back(8'h33); fifo_q.push_back(8'h44);
        wait_beats("t1_beats", 1);

        // 2: partial word via flush, then flush with nothing packed
        fifo_q.push_back(8'hA5); fifo_q.push_back(8'h5A);
        wait_idle();
        push_exp(32'h00005AA5, 3'd2);
        pulse_flush();
        wait_beats("t2_beats", 2);
        pulse_flush();
        tick(20);
        check("t2_empty_flush", 64'(beats), 2);

        // 3: back-pressure holds the word and blocks reads
        bus.out_ready = 1'b0;
        push_exp(32'h04030201, 3'd4);
        fifo_q.push_back(8'h01); fifo_q.push_back(8'h02);
        fifo_q.push_back(8'h03); fifo_q.push_back(8'h04);
        fifo_q.push_back(8'h99);
        for (int i = 0; i < 200 && !bus.out_valid; i++) tick();
        for (int i = 0; i < 10; i++) begin
            check("t3_valid_hold", 64'(bus.out_valid),  1);
            check("t3_data_hold",  64'(bus.out_data),   64'h04030201);
            check("t3_no_read",    64'(bus.fifo_rd_en), 0);
            tick();
        end
        check("t3_fifo_untouched", 64'(fifo_q.size()), 1);
        bus.out_ready = 1'b1;
        wait_beats("t3_beats", 3);
        wait_idle();
        push_exp(32'h00000099, 3'd1);
        pulse_flush();
        wait_beats("t3_flush_beats", 4);

        // 4: 300 read errors saturate err_cnt, nothing captured
        fifo_q.push_back(8'h10); fifo_q.push_back(8'h20);
        wait_idle();
        mode = 1;
        fifo_q.push_back(8'h30);
        for (int i = 0; i < 2000 && err_given < 300; i++) tick();
        check("t4_err_given", 64'(err_given >= 300), 1);
        mode = 0;
        tick(5);
        check("t4_err_sat", 64'(bus.err_cnt), 255);
        push_exp(32'h40302010, 3'd4);
        fifo_q.push_back(8'h40);
        wait_beats("t4_beats", 5);

        // 5: reset in WAIT with idx=2 discards the partial word
        fifo_q.push_back(8'h55); fifo_q.push_back(8'h66);
        wait_idle();
        mode = 2;
        fifo_q.push_back(8'h77);
        tick(6);
        clear_n = 1'b0;
        #1;
        check("t5_rd_en",     64'(bus.fifo_rd_en), 0);
        check("t5_out_valid", 64'(bus.out_valid),  0);
        check("t5_out_data",  64'(bus.out_data),   0);
        check("t5_out_cnt",   64'(bus.out_cnt),    0);
        check("t5_err_cnt",   64'(bus.err_cnt),    0);
        mode = 0;
        tick(2);
        clear_n = 1'b1;
        push_exp(32'hAA998877, 3'd4);
        fifo_q.push_back(8'h88); fifo_q.push_back(8'h99); fifo_q.push_back(8'hAA);
        wait_beats("t5_beats", 6);

`ifdef FIFO_RD_TIMEOUT_EN
        // 6: silent FIFO -> timeout pulse, err_cnt+1, retry from IDLE
        begin
            logic seen;
            seen = 1'b0;
            mode = 2;
            fifo_q.push_back(8'h01);
            for (int i = 0; i < 100 && !seen; i++) begin
                tick();
                if (bus.timeout_err) seen = 1'b1;
            end
            check("t6_timeout_seen", 64'(seen), 1);
            tick();
            check("t6_timeout_pulse", 64'(bus.timeout_err), 0);
            check("t6_err_cnt",       64'(bus.err_cnt),     1);
            mode = 0;
            wait_idle();
            push_exp(32'h00000001, 3'd1);
            pulse_flush();
            wait_beats("t6_beats", 7);
        end
`endif

        tick(5);
        check("exp_queue_drained", 64'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
